fp_align_prep: RTL and testbench



---
 rtl/FPALL_pkg.sv | 16 +
 rtl/fp_lane_cmp.sv | 47 ++++
 rtl/fp_align_prep.sv | 145 ++++++++++++++
 tb/tb_fp_align_prep.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/FPALL_pkg.sv
// Shared format, lane-width and packing constants for the FP alignment front end.
package FPALL_pkg;

  typedef enum logic {
    FMT_FP32 = 1'b0,
    FMT_FP16 = 1'b1
  } fp_fmt_e;

  localparam int unsigned EXP_W          = 8;
  localparam int unsigned FP32_SIG_W     = 24;
  localparam int unsigned FP16_SIG_W     = 8;
  localparam int unsigned FP32_SHIFT_MAX = 31;
  localparam int unsigned FP16_SHIFT_MAX = 15;
  localparam int unsigned PACK_GAP_W     = 8;

endpackage

// File: rtl/fp_lane_cmp.sv
// One lane: unpack, magnitude compare/swap, clamped exponent difference, Inf/NaN detect.
module fp_lane_cmp #(
  parameter int unsigned EXP_W     = 8,
  parameter int unsigned FRAC_W    = 23,
  parameter int unsigned SHIFT_MAX = 31,
  localparam int unsigned SHIFT_W  = $clog2(SHIFT_MAX + 1)
) (
  input  logic               a_sign,
  input  logic [EXP_W-1:0]   a_exp,
  input  logic [FRAC_W-1:0]  a_frac,
  input  logic               b_sign,
  input  logic [EXP_W-1:0]   b_exp,
  input  logic [FRAC_W-1:0]  b_frac,
  output logic [FRAC_W:0]    big_sig,
  output logic [FRAC_W:0]    small_sig,
  output logic [EXP_W-1:0]   big_exp,
  output logic [SHIFT_W-1:0] shift,
  output logic               sign,
  output logic               eff_sub,
  output logic               special
);

  localparam logic [EXP_W-1:0] MAX_E = EXP_W'(SHIFT_MAX);

  logic             a_big;
  logic [EXP_W-1:0] a_eexp, b_eexp, small_exp, diff;
  logic [FRAC_W:0]  a_sig, b_sig;

  always_comb begin
    // Raw {exp,frac} ordering equals magnitude ordering; ties keep a as big.
    a_big     = {a_exp, a_frac} >= {b_exp, b_frac};
    a_eexp    = (a_exp == '0) ? EXP_W'(1) : a_exp;
    b_eexp    = (b_exp == '0) ? EXP_W'(1) : b_exp;
    a_sig     = {a_exp != '0, a_frac};
    b_sig     = {b_exp != '0, b_frac};
    big_sig   = a_big ? a_sig  : b_sig;
    small_sig = a_big ? b_sig  : a_sig;
    big_exp   = a_big ? a_eexp : b_eexp;
    small_exp = a_big ? b_eexp : a_eexp;
    diff      = big_exp - small_exp;
    shift     = (diff > MAX_E) ? SHIFT_W'(SHIFT_MAX) : diff[SHIFT_W-1:0];
    sign      = a_big ? a_sign : b_sign;
    eff_sub   = a_sign ^ b_sign;
    special   = (&a_exp) | (&b_exp);
  end

endmodule

// File: rtl/fp_align_prep.sv
// Two-stage valid/ready operand alignment prep: S1 holds operands, S2 holds packed swap/shift results.
module fp_align_prep
  import FPALL_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  fp_fmt_e     fmt,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output fp_fmt_e     out_fmt,
  output logic [23:0] out_X,
  output logic [7:0]  out_S,
  output logic [23:0] out_big,
  output logic [15:0] out_exp,
  output logic [1:0]  out_sign,
  output logic [1:0]  out_eff_sub,
  output logic [1:0]  out_special
);

  logic        s1_valid, s2_valid, s1_adv, s2_adv;
  fp_fmt_e     s1_fmt, s2_fmt;
  logic [31:0] s1_a, s1_b;
  logic [23:0] s2_X, s2_big, n_X, n_big;
  logic [7:0]  s2_S, n_S;
  logic [15:0] s2_exp, n_exp;
  logic [1:0]  s2_sign, s2_eff, s2_spec, n_sign, n_eff, n_spec;

  logic [FP32_SIG_W-1:0] w_big, w_small;
  logic [EXP_W-1:0]      w_exp;
  logic [4:0]            w_shift;
  logic                  w_sign, w_eff, w_spec;
  logic [FP16_SIG_W-1:0] h_big, h_small, l_big, l_small;
  logic [EXP_W-1:0]      h_exp, l_exp;
  logic [3:0]            h_shift, l_shift;
  logic                  h_sign, h_eff, h_spec, l_sign, l_eff, l_spec;

  fp_lane_cmp #(.EXP_W(EXP_W), .FRAC_W(FP32_SIG_W - 1), .SHIFT_MAX(FP32_SHIFT_MAX)) u_cmp32 (
    .a_sign(s1_a[31]), .a_exp(s1_a[30:23]), .a_frac(s1_a[22:0]),
    .b_sign(s1_b[31]), .b_exp(s1_b[30:23]), .b_frac(s1_b[22:0]),
    .big_sig(w_big), .small_sig(w_small), .big_exp(w_exp), .shift(w_shift),
    .sign(w_sign), .eff_sub(w_eff), .special(w_spec)
  );

  fp_lane_cmp #(.EXP_W(EXP_W), .FRAC_W(FP16_SIG_W - 1), .SHIFT_MAX(FP16_SHIFT_MAX)) u_cmp_hi (
    .a_sign(s1_a[31]), .a_exp(s1_a[30:23]), .a_frac(s1_a[22:16]),
    .b_sign(s1_b[31]), .b_exp(s1_b[30:23]), .b_frac(s1_b[22:16]),
    .big_sig(h_big), .small_sig(h_small), .big_exp(h_exp), .shift(h_shift),
    .sign(h_sign), .eff_sub(h_eff), .special(h_spec)
  );

  fp_lane_cmp #(.EXP_W(EXP_W), .FRAC_W(FP16_SIG_W - 1), .SHIFT_MAX(FP16_SHIFT_MAX)) u_cmp_lo (
    .a_sign(s1_a[15]), .a_exp(s1_a[14:7]), .a_frac(s1_a[6:0]),
    .b_sign(s1_b[15]), .b_exp(s1_b[14:7]), .b_frac(s1_b[6:0]),
    .big_sig(l_big), .small_sig(l_small), .big_exp(l_exp), .shift(l_shift),
    .sign(l_sign), .eff_sub(l_eff), .special(l_spec)
  );

  always_comb begin
    n_X    = '0;
    n_big  = '0;
    n_S    = '0;
    n_exp  = '0;
    n_sign = '0;
    n_eff  = '0;
    n_spec = '0;
    if (s1_fmt == FMT_FP32) begin
      n_X    = w_small;
      n_big  = w_big;
      n_S    = {3'b000, w_shift};
      n_exp  = {8'h00, w_exp};
      n_sign = {1'b0, w_sign};
      n_eff  = {1'b0, w_eff};
      n_spec = {1'b0, w_spec};
    end else begin
      n_X    = {h_small, {PACK_GAP_W{1'b0}}, l_small};
      n_big  = {h_big, {PACK_GAP_W{1'b0}}, l_big};
      n_S    = {h_shift, l_shift};
      n_exp  = {h_exp, l_exp};
      n_sign = {h_sign, l_sign};
      n_eff  = {h_eff, l_eff};
      n_spec = {h_spec, l_spec};
    end
  end

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = rst || s1_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_fmt   <= FMT_FP32;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_fmt   <= FMT_FP32;
      s2_X     <= '0;
      s2_big   <= '0;
      s2_S     <= '0;
      s2_exp   <= '0;
      s2_sign  <= '0;
      s2_eff   <= '0;
      s2_spec  <= '0;
    end else begin
      if (flush)       s1_valid <= 1'b0;
      else if (s1_adv) s1_valid <= in_valid;
      if (flush)       s2_valid <= 1'b0;
      else if (s2_adv) s2_valid <= s1_valid;
      if (s1_adv && in_valid) begin
        s1_fmt <= fmt;
        s1_a   <= a;
        s1_b   <= b;
      end
      if (s2_adv && s1_valid) begin
        s2_fmt  <= s1_fmt;
        s2_X    <= n_X;
        s2_big  <= n_big;
        s2_S    <= n_S;
        s2_exp  <= n_exp;
        s2_sign <= n_sign;
        s2_eff  <= n_eff;
        s2_spec <= n_spec;
      end
    end
  end

  // Data outputs are forced to zero for the whole reset cycle, not just after the edge.
  always_comb begin
    out_valid   = s2_valid;
    out_fmt     = rst ? FMT_FP32 : s2_fmt;
    out_X       = rst ? '0 : s2_X;
    out_big     = rst ? '0 : s2_big;
    out_S       = rst ? '0 : s2_S;
    out_exp     = rst ? '0 : s2_exp;
    out_sign    = rst ? '0 : s2_sign;
    out_eff_sub = rst ? '0 : s2_eff;
    out_special = rst ? '0 : s2_spec;
  end

endmodule

// File: tb/tb_fp_align_prep.sv
// Bench for fp_align_prep: arithmetic reference model + scoreboard, plus directed literal vectors.
module tb_fp_align_prep;
  import FPALL_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  fp_fmt_e     fmt = FMT_FP32;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid;
  fp_fmt_e     out_fmt;
  logic [23:0] out_X, out_big;
  logic [7:0]  out_S;
  logic [15:0] out_exp;
  logic [1:0]  out_sign, out_eff_sub, out_special;

  fp_align_prep dut (
    .clk(clk), .rst(rst), .fmt(fmt), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_fmt(out_fmt), .out_X(out_X), .out_S(out_S), .out_big(out_big),
    .out_exp(out_exp), .out_sign(out_sign), .out_eff_sub(out_eff_sub),
    .out_special(out_special)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [23:0] x;
    logic [7:0]  s;
    logic [23:0] big;
    logic [15:0] e;
    logic [1:0]  sign;
    logic [1:0]  eff;
    logic [1:0]  spec;
    logic        fmt;
  } res_t;

  // Operand in low bits as sign|exp|frac; magnitude = value with sign stripped.
  function automatic void lane(input int unsigned ew, input int unsigned fw, input int unsigned smax,
                               input logic [31:0] va, input logic [31:0] vb,
                               output int unsigned sig_b, output int unsigned sig_s,
                               output int unsigned e_b, output int unsigned sh,
                               output logic sg, output logic es, output logic sp);
    int unsigned mask  = (32'd1 << (ew + fw)) - 32'd1;
    int unsigned mag_a = va & mask;
    int unsigned mag_b = vb & mask;
    int unsigned ea    = mag_a >> fw;
    int unsigned eb    = mag_b >> fw;
    int unsigned one   = 32'd1 << fw;
    int unsigned ea_e  = (ea == 0) ? 1 : ea;
    int unsigned eb_e  = (eb == 0) ? 1 : eb;
    int unsigned sa    = (ea == 0 ? 0 : one) + (mag_a % one);
    int unsigned sb    = (eb == 0 ? 0 : one) + (mag_b % one);
    int unsigned emax  = (32'd1 << ew) - 1;
    bit          a_big = (mag_a >= mag_b);
    sig_b = a_big ? sa : sb;
    sig_s = a_big ? sb : sa;
    e_b   = a_big ? ea_e : eb_e;
    sh    = a_big ? ea_e - eb_e : eb_e - ea_e;
    if (sh > smax) sh = smax;
    sg = a_big ? va[ew+fw] : vb[ew+fw];
    es = va[ew+fw] ^ vb[ew+fw];
    sp = (ea == emax) || (eb == emax);
  endfunction

  function automatic res_t model(input fp_fmt_e f, input logic [31:0] va, input logic [31:0] vb);
    res_t r;
    int unsigned bh, sh_, eh, shh, bl, sl, el, shl;
    logic gh, xh, ph, gl, xl, pl;
    r = '0;
    r.fmt = f;
    if (f == FMT_FP32) begin
      lane(8, 23, 31, va, vb, bh, sh_, eh, shh, gh, xh, ph);
      r.x = 24'(sh_); r.big = 24'(bh); r.s = 8'(shh); r.e = 16'(eh);
      r.sign = {1'b0, gh}; r.eff = {1'b0, xh}; r.spec = {1'b0, ph};
    end else begin
      lane(8, 7, 15, va >> 16, vb >> 16, bh, sh_, eh, shh, gh, xh, ph);
      lane(8, 7, 15, va & 32'hFFFF, vb & 32'hFFFF, bl, sl, el, shl, gl, xl, pl);
      r.x = 24'(sh_ * 65536 + sl); r.big = 24'(bh * 65536 + bl);
      r.s = 8'(shh * 16 + shl); r.e = 16'(eh * 256 + el);
      r.sign = {gh, gl}; r.eff = {xh, xl}; r.spec = {ph, pl};
    end
    return r;
  endfunction

  res_t q[$];
  res_t prev, cur;
  logic prev_hold = 1'b0;

  always @(negedge clk) begin
    cur = {out_X, out_S, out_big, out_exp, out_sign, out_eff_sub, out_special, logic'(out_fmt)};
    if (!rst) begin
      check("in_ready_model", in_ready, (q.size() < 2) || out_ready);
      if (out_valid) begin
        if (q.size() == 0) check("out_valid_without_entry", 1'b1, 1'b0);
        else check("out_entry", cur, q[0]);
      end
      if (q.size() == 2) check("out_valid_when_full", out_valid, 1'b1);
      if (prev_hold) check("hold_stable", cur, prev);
    end
    prev_hold = out_valid && !out_ready && !rst && !flush;
    prev = cur;
    if (rst || flush) q.delete();
    else begin
      if (out_valid && out_ready) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(model(fmt, a, b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input fp_fmt_e f, input logic [31:0] va, input logic [31:0] vb);
    bit ok = 0;
    fmt = f; a = va; b = vb; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) check("send_timeout", 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) return;
    end
    check("out_valid_timeout", 1'b0, 1'b1);
  endtask

  logic [31:0] tva[8] = '{32'h00000003, 32'h7F800000, 32'h7FC00001, 32'hC1200000,
                          32'h7F80_3C00, 32'h0001_8000, 32'h4040_0000, 32'h0000_0000};
  logic [31:0] tvb[8] = '{32'h00400000, 32'h3F800000, 32'hC0000000, 32'h41200000,
                          32'h3C00_7FC0, 32'h0002_0001, 32'hC040_0040, 32'h8000_8000};
  fp_fmt_e     tvf[8] = '{FMT_FP32, FMT_FP32, FMT_FP32, FMT_FP32,
                          FMT_FP16, FMT_FP16, FMT_FP16, FMT_FP16};

  initial begin
    int lat, acc, drn, idx;
    logic [23:0] snap;

    // Reset behaviour
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_X", out_X, 24'h0);
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    tick();

    // FP32 3.0 vs 1.0
    out_ready = 1'b1;
    send(FMT_FP32, 32'h40400000, 32'h3F800000);
    wait_out(lat);
    check("fp32_latency", lat, 2);
    check("fp32_S", out_S, 8'h01);
    check("fp32_X", out_X, 24'h800000);
    check("fp32_big", out_big, 24'hC00000);
    check("fp32_exp", out_exp, 16'h0080);
    check("fp32_effsub", out_eff_sub, 2'b00);
    tick();

    // FP16 two lanes: hi 3.0 vs 1.0, lo -1.0 vs 8.0
    send(FMT_FP16, 32'h4040BF80, 32'h3F804100);
    wait_out(lat);
    check("fp16_S", out_S, 8'h13);
    check("fp16_gap", out_X[15:8], 8'h00);
    check("fp16_X", out_X, 24'h800080);
    check("fp16_big", out_big, 24'hC00080);
    check("fp16_exp", out_exp, 16'h8082);
    check("fp16_sign", out_sign, 2'b00);
    check("fp16_effsub", out_eff_sub, 2'b01);
    tick();

    // Shift clamps
    send(FMT_FP32, 32'h7E000000, 32'h00000001);
    wait_out(lat);
    check("clamp32_S", out_S, 8'h1F);
    check("clamp32_X", out_X, 24'h000001);
    tick();
    send(FMT_FP16, 32'h28000000, 32'h14000000);
    wait_out(lat);
    check("clamp16_S", out_S, 8'hF0);
    tick();

    // Ties: a is big
    send(FMT_FP32, 32'h3F800000, 32'h3F800000);
    wait_out(lat);
    check("tie_S", out_S, 8'h00);
    check("tie_X", out_X, 24'h800000);
    check("tie_big", out_big, 24'h800000);
    check("tie_sign", out_sign, 2'b00);
    tick();
    send(FMT_FP32, 32'h80000000, 32'h00000000);
    wait_out(lat);
    check("tie_zero_sign_from_a", out_sign, 2'b01);
    tick(); tick();

    // Backpressure: 5 cycles of offered input, downstream stalled
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    fmt = FMT_FP32;
    for (int i = 0; i < 5; i++) begin
      a = 32'h3F800000 + 32'(i) * 32'h00800000;
      b = 32'h3F000000;
      @(negedge clk);
      if (in_ready) acc++;
      if (i == 2) snap = out_X;
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_accepted", acc, 2);
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_out_X_held", out_X, snap);
    tick();
    out_ready = 1'b1;
    drn = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) drn++;
    end
    check("bp_drained", drn, 2);
    tick();

    // Flush with both stages full, plus a same-cycle offered input
    out_ready = 1'b0;
    send(FMT_FP32, 32'h40000000, 32'h3F800000);
    send(FMT_FP32, 32'h40800000, 32'h3F800000);
    @(negedge clk);
    check("flush_pre_valid", out_valid, 1'b1);
    tick();
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; a = 32'h41000000;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_no_ghost", out_valid, 1'b0);
    end
    tick();

    // Reset mid-stream
    out_ready = 1'b0;
    send(FMT_FP16, 32'h40004000, 32'h3C003C00);
    send(FMT_FP32, 32'h40000000, 32'h3F800000);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", in_ready, 1'b1);
    check("rst_mid_out_S", out_S, 8'h00);
    check("rst_mid_out_big", out_big, 24'h0);
    tick();
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 1'b0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_emit", out_valid, 1'b0);
    end
    tick();

    // Table plus random operands under random downstream stalls
    idx = 0;
    for (int cyc = 0; cyc < 400 && idx < 40; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 3) != 0);
      if (idx < 8) begin
        fmt = tvf[idx]; a = tva[idx]; b = tvb[idx];
      end else if (in_valid && (a == 32'h0 || idx != 99)) begin
        fmt = fp_fmt_e'($urandom_range(0, 1));
        a = $urandom; b = $urandom;
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      tick();
    end
    check("stream_count", idx, 40);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("scoreboard_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
